// File: rtl/vga_axil_pkg.sv
// Shared types and constants for the VGA AXI4-Lite register file.
package vga_axil_pkg;

   typedef logic [1:0]  axil_resp_t;
   typedef logic [31:0] axil_addr_t;
   typedef logic [31:0] axil_data_t;

   localparam axil_resp_t AXIL_RESP_OKAY   = 2'b00;
   localparam axil_resp_t AXIL_RESP_SLVERR = 2'b10;
   localparam axil_resp_t AXIL_RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {
      W_IDLE,
      W_HAVE_AW,
      W_HAVE_W,
      W_RESP
   } wr_state_e;

   typedef enum logic {
      R_IDLE,
      R_RESP
   } rd_state_e;

endpackage

// File: rtl/vga_axil_wr_ctrl.sv
// AXI4-Lite write-channel controller: captures AW and W in either order,
// classifies the access and drives the B channel. The commit strobe is
// asserted on the edge that enters W_RESP.
module vga_axil_wr_ctrl
   import vga_axil_pkg::*;
#(
   parameter int unsigned         ADDR_W  = 32,
   parameter int unsigned         DATA_W  = 32,
   parameter int unsigned         REG_NUM = 16,
   parameter logic [REG_NUM-1:0]  RO_MASK = '0
) (
   input  logic                       clk,
   input  logic                       arst_n,
   input  logic [ADDR_W-1:0]          awaddr,
   input  logic                       awvalid,
   output logic                       awready,
   input  logic [DATA_W-1:0]          wdata,
   input  logic [DATA_W/8-1:0]        wstrb,
   input  logic                       wvalid,
   output logic                       wready,
   output axil_resp_t                 bresp,
   output logic                       bvalid,
   input  logic                       bready,
   output logic                       commit,
   output logic [$clog2(REG_NUM)-1:0] commit_idx,
   output logic [DATA_W-1:0]          commit_data,
   output logic [DATA_W/8-1:0]        commit_strb,
   output axil_resp_t                 commit_resp
);

   localparam int unsigned ByteW = DATA_W / 8;
   localparam int unsigned OffW  = $clog2(ByteW);
   localparam int unsigned IdxW  = $clog2(REG_NUM);

   wr_state_e           state_q, state_d;
   logic [ADDR_W-1:0]   aw_addr_q;
   logic [DATA_W-1:0]   w_data_q;
   logic [ByteW-1:0]    w_strb_q;
   axil_resp_t          bresp_q;
   logic                aw_hs, w_hs;
   logic [ADDR_W-1:0]   cur_addr;
   logic                unused_addr_bits;

   // Readies come from state only, so no input reaches them combinationally.
   assign awready = (state_q == W_IDLE) || (state_q == W_HAVE_W);
   assign wready  = (state_q == W_IDLE) || (state_q == W_HAVE_AW);
   assign bvalid  = (state_q == W_RESP);
   assign bresp   = bresp_q;
   assign aw_hs   = awvalid && awready;
   assign w_hs    = wvalid && wready;

   // A half already captured comes from its latch, the other from the live bus.
   assign cur_addr    = (state_q == W_HAVE_AW) ? aw_addr_q : awaddr;
   assign commit_data = (state_q == W_HAVE_W) ? w_data_q : wdata;
   assign commit_strb = (state_q == W_HAVE_W) ? w_strb_q : wstrb;
   assign commit_idx  = cur_addr[OffW +: IdxW];

   assign unused_addr_bits = ^cur_addr[OffW-1:0];

   // Classify the access: out-of-range first, then read-only slots.
   always_comb begin
      commit_resp = AXIL_RESP_OKAY;
      if (|cur_addr[ADDR_W-1:OffW+IdxW]) begin
         commit_resp = AXIL_RESP_DECERR;
      end else if (RO_MASK[commit_idx]) begin
         commit_resp = AXIL_RESP_SLVERR;
      end
   end

   // Next-state and commit strobe.
   always_comb begin
      state_d = state_q;
      commit  = 1'b0;
      case (state_q)
         W_IDLE: begin
            if (aw_hs && w_hs) begin
               state_d = W_RESP;
               commit  = 1'b1;
            end else if (aw_hs) begin
               state_d = W_HAVE_AW;
            end else if (w_hs) begin
               state_d = W_HAVE_W;
            end
         end
         W_HAVE_AW: begin
            if (w_hs) begin
               state_d = W_RESP;
               commit  = 1'b1;
            end
         end
         W_HAVE_W: begin
            if (aw_hs) begin
               state_d = W_RESP;
               commit  = 1'b1;
            end
         end
         W_RESP: begin
            if (bready) state_d = W_IDLE;
         end
         default: state_d = W_IDLE;
      endcase
   end

   // State register, channel captures and registered response.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q   <= W_IDLE;
         aw_addr_q <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         bresp_q   <= AXIL_RESP_OKAY;
      end else begin
         state_q <= state_d;
         if (aw_hs) aw_addr_q <= awaddr;
         if (w_hs) begin
            w_data_q <= wdata;
            w_strb_q <= wstrb;
         end
         if (commit) bresp_q <= commit_resp;
      end
   end

endmodule

// File: rtl/vga_axil_regfile.sv
// AXI4-Lite register file for the VGA core. Holds REG_NUM control registers,
// mirrors hw_regs_i into read-only slots and answers OKAY/SLVERR/DECERR.
// Optional build macro VGA_AXIL_REGFILE_STRB_EN enables per-byte write strobes.
module vga_axil_regfile
   import vga_axil_pkg::*;
#(
   parameter int unsigned        ADDR_W  = 32,
   parameter int unsigned        DATA_W  = 32,
   parameter int unsigned        REG_NUM = 16,
   parameter logic [REG_NUM-1:0] RO_MASK = '0
) (
   input  logic                        clk,
   input  logic                        arst_n,
   input  logic [ADDR_W-1:0]           araddr,
   input  logic                        arvalid,
   output logic                        arready,
   output logic [DATA_W-1:0]           rdata,
   output axil_resp_t                  rresp,
   output logic                        rvalid,
   input  logic                        rready,
   input  logic [ADDR_W-1:0]           awaddr,
   input  logic                        awvalid,
   output logic                        awready,
   input  logic [DATA_W-1:0]           wdata,
   input  logic [DATA_W/8-1:0]         wstrb,
   input  logic                        wvalid,
   output logic                        wready,
   output axil_resp_t                  bresp,
   output logic                        bvalid,
   input  logic                        bready,
   output logic [REG_NUM*DATA_W-1:0]   regs_o,
   output logic [REG_NUM-1:0]          wr_pulse_o,
   input  logic [REG_NUM*DATA_W-1:0]   hw_regs_i
);

   localparam int unsigned ByteW = DATA_W / 8;
   localparam int unsigned OffW  = $clog2(ByteW);
   localparam int unsigned IdxW  = $clog2(REG_NUM);

   logic [DATA_W-1:0]   regs_q  [REG_NUM];
   logic [DATA_W-1:0]   hw_slot [REG_NUM];
   logic [REG_NUM-1:0]  wr_pulse_q, wr_pulse_d;

   logic                wr_commit, wr_en;
   logic [IdxW-1:0]     wr_idx;
   logic [DATA_W-1:0]   wr_data;
   logic [ByteW-1:0]    wr_strb;
   axil_resp_t          wr_resp;

   rd_state_e           rd_state_q, rd_state_d;
   logic [DATA_W-1:0]   rdata_q, rd_data_d;
   axil_resp_t          rresp_q, rd_resp_d;
   logic [IdxW-1:0]     ar_idx;
   logic                ar_hs;
   logic                unused_araddr_bits;

   vga_axil_wr_ctrl #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .REG_NUM (REG_NUM),
      .RO_MASK (RO_MASK)
   ) u_wr_ctrl (
      .clk         (clk),
      .arst_n      (arst_n),
      .awaddr      (awaddr),
      .awvalid     (awvalid),
      .awready     (awready),
      .wdata       (wdata),
      .wstrb       (wstrb),
      .wvalid      (wvalid),
      .wready      (wready),
      .bresp       (bresp),
      .bvalid      (bvalid),
      .bready      (bready),
      .commit      (wr_commit),
      .commit_idx  (wr_idx),
      .commit_data (wr_data),
      .commit_strb (wr_strb),
      .commit_resp (wr_resp)
   );

   assign wr_en = wr_commit && (wr_resp == AXIL_RESP_OKAY);

`ifndef VGA_AXIL_REGFILE_STRB_EN
   logic unused_wr_strb;
   assign unused_wr_strb = ^wr_strb;
`endif

   // Commit accepted writes into the register array.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         for (int unsigned i = 0; i < REG_NUM; i++) regs_q[i] <= '0;
      end else if (wr_en) begin
`ifdef VGA_AXIL_REGFILE_STRB_EN
         for (int unsigned k = 0; k < ByteW; k++) begin
            if (wr_strb[k]) regs_q[wr_idx][k*8 +: 8] <= wr_data[k*8 +: 8];
         end
`else
         regs_q[wr_idx] <= wr_data;
`endif
      end
   end

   // One-hot pulse for the register just written; zero-strobe writes still count.
   always_comb begin
      wr_pulse_d = '0;
      if (wr_en) wr_pulse_d[wr_idx] = 1'b1;
   end

   // Pulse register, high for the single cycle after the commit edge.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) wr_pulse_q <= '0;
      else         wr_pulse_q <= wr_pulse_d;
   end

   assign wr_pulse_o = wr_pulse_q;

   // Flatten the array onto regs_o and split hw_regs_i into slots.
   always_comb begin
      for (int unsigned i = 0; i < REG_NUM; i++) begin
         regs_o[i*DATA_W +: DATA_W] = regs_q[i];
         hw_slot[i]                 = hw_regs_i[i*DATA_W +: DATA_W];
      end
   end

   assign arready = (rd_state_q == R_IDLE);
   assign rvalid  = (rd_state_q == R_RESP);
   assign rdata   = rdata_q;
   assign rresp   = rresp_q;
   assign ar_hs   = arvalid && arready;
   assign ar_idx  = araddr[OffW +: IdxW];

   assign unused_araddr_bits = ^araddr[OffW-1:0];

   // Read decode; regs_q is sampled before any same-edge write lands.
   always_comb begin
      rd_data_d = '0;
      rd_resp_d = AXIL_RESP_OKAY;
      if (|araddr[ADDR_W-1:OffW+IdxW]) begin
         rd_resp_d = AXIL_RESP_DECERR;
      end else if (RO_MASK[ar_idx]) begin
         rd_data_d = hw_slot[ar_idx];
      end else begin
         rd_data_d = regs_q[ar_idx];
      end
   end

   // Read FSM next-state.
   always_comb begin
      rd_state_d = rd_state_q;
      case (rd_state_q)
         R_IDLE:  if (arvalid) rd_state_d = R_RESP;
         R_RESP:  if (rready)  rd_state_d = R_IDLE;
         default: rd_state_d = R_IDLE;
      endcase
   end

   // Read FSM state and held response.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         rd_state_q <= R_IDLE;
         rdata_q    <= '0;
         rresp_q    <= AXIL_RESP_OKAY;
      end else begin
         rd_state_q <= rd_state_d;
         if (ar_hs) begin
            rdata_q <= rd_data_d;
            rresp_q <= rd_resp_d;
         end
      end
   end

endmodule

// File: tb/tb_vga_axil_regfile.sv
// Self-checking bench for vga_axil_regfile with RO_MASK = 16'h8000.
module tb_vga_axil_regfile;

   localparam int ADDR_W  = 32;
   localparam int DATA_W  = 32;
   localparam int REG_NUM = 16;
   localparam logic [15:0] RO = 16'h8000;

   logic          clk, arst_n;
   logic [31:0]   araddr, awaddr, wdata, rdata;
   logic          arvalid, arready, rvalid, rready;
   logic          awvalid, awready, wvalid, wready, bvalid, bready;
   logic [3:0]    wstrb;
   logic [1:0]    rresp, bresp;
   logic [511:0]  regs_o, hw_regs_i;
   logic [15:0]   wr_pulse_o;

   int errors = 0;
   int checks = 0;
   logic [31:0] model [16];

   vga_axil_regfile #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .REG_NUM (REG_NUM),
      .RO_MASK (RO)
   ) dut (
      .clk        (clk),
      .arst_n     (arst_n),
      .araddr     (araddr),
      .arvalid    (arvalid),
      .arready    (arready),
      .rdata      (rdata),
      .rresp      (rresp),
      .rvalid     (rvalid),
      .rready     (rready),
      .awaddr     (awaddr),
      .awvalid    (awvalid),
      .awready    (awready),
      .wdata      (wdata),
      .wstrb      (wstrb),
      .wvalid     (wvalid),
      .wready     (wready),
      .bresp      (bresp),
      .bvalid     (bvalid),
      .bready     (bready),
      .regs_o     (regs_o),
      .wr_pulse_o (wr_pulse_o),
      .hw_regs_i  (hw_regs_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // ---------------- reference model ----------------
   function automatic logic [1:0] exp_resp(input logic [31:0] a, input bit wr);
      if (a >= 32'd64) return 2'b11;
      if (((a >> 2) & 32'd15) == 32'd15) return wr ? 2'b10 : 2'b00;
      return 2'b00;
   endfunction

   function automatic int idx_of(input logic [31:0] a);
      return int'((a >> 2) & 32'd15);
   endfunction

   function automatic logic [511:0] model_flat();
      logic [511:0] f;
      for (int i = 0; i < 16; i++) f[i*32 +: 32] = model[i];
      return f;
   endfunction

   function automatic logic [31:0] exp_read(input logic [31:0] a);
      if (exp_resp(a, 1'b0) == 2'b11) return 32'h0;
      if (idx_of(a) == 15) return hw_regs_i[15*32 +: 32];
      return model[idx_of(a)];
   endfunction

   task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      int i;
      if (exp_resp(a, 1'b1) == 2'b00) begin
         i = idx_of(a);
`ifdef VGA_AXIL_REGFILE_STRB_EN
         for (int k = 0; k < 4; k++) if (s[k]) model[i][k*8 +: 8] = d[k*8 +: 8];
`else
         model[i] = d;
`endif
      end
   endtask

   function automatic logic [15:0] exp_pulse(input logic [31:0] a);
      logic [15:0] p;
      p = '0;
      if (exp_resp(a, 1'b1) == 2'b00) p[idx_of(a)] = 1'b1;
      return p;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 16; i++) model[i] = '0;
   endtask

   // ---------------- bus transactions ----------------
   task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly,
                            output bit b_ok, output logic [1:0] resp, output logic [15:0] pulse,
                            output logic [511:0] regs, output bit b_gone,
                            output logic [15:0] pulse_after);
      int cyc;
      bit aw_done, w_done, hs_aw, hs_w;
      aw_done = 0;
      w_done  = 0;
      cyc     = 0;
      while (!(aw_done && w_done) && cyc < 40) begin
         @(negedge clk);
         awaddr  = a;
         wdata   = d;
         wstrb   = s;
         awvalid = !aw_done && (cyc >= aw_dly);
         wvalid  = !w_done && (cyc >= w_dly);
         hs_aw   = awvalid && awready;
         hs_w    = wvalid && wready;
         @(posedge clk);
         if (hs_aw) aw_done = 1;
         if (hs_w)  w_done = 1;
         cyc++;
      end
      @(negedge clk);
      awvalid = 0;
      wvalid  = 0;
      b_ok    = aw_done && w_done && (bvalid === 1'b1);
      resp    = bresp;
      pulse   = wr_pulse_o;
      regs    = regs_o;
      bready  = 1;
      @(posedge clk);
      @(negedge clk);
      bready      = 0;
      b_gone      = (bvalid === 1'b0);
      pulse_after = wr_pulse_o;
   endtask

   task automatic axi_read(input logic [31:0] a, output bit r_ok, output logic [31:0] data,
                           output logic [1:0] resp, output bit r_gone);
      int n;
      @(negedge clk);
      araddr  = a;
      arvalid = 1;
      n = 0;
      while (!arready && n < 40) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      @(negedge clk);
      arvalid = 0;
      r_ok    = (n < 40) && (rvalid === 1'b1);
      data    = rdata;
      resp    = rresp;
      rready  = 1;
      @(posedge clk);
      @(negedge clk);
      rready = 0;
      r_gone = (rvalid === 1'b0);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      checks++;
      if ({arready, awready, wready} !== 3'b111) begin
         errors++; $display("FAIL rst_readies: got %b want 111", {arready, awready, wready});
      end
      checks++;
      if ({rvalid, bvalid} !== 2'b00) begin
         errors++; $display("FAIL rst_valids: got %b want 00", {rvalid, bvalid});
      end
      checks++;
      if (rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", rdata); end
      checks++;
      if ({rresp, bresp} !== 4'h0) begin
         errors++; $display("FAIL rst_resp: got %h want 0", {rresp, bresp});
      end
      checks++;
      if (wr_pulse_o !== 16'h0) begin
         errors++; $display("FAIL rst_pulse: got %h want 0", wr_pulse_o);
      end
      checks++;
      if (regs_o !== 512'h0) begin errors++; $display("FAIL rst_regs: got nonzero regs_o"); end
   endtask

   task automatic test_basic_write();
      bit b_ok, b_gone, r_ok, r_gone;
      logic [1:0] resp;
      logic [15:0] pulse, pulse_after;
      logic [511:0] regs;
      logic [31:0] data;
      axi_write(32'h4, 32'hDEADBEEF, 4'hF, 0, 0, b_ok, resp, pulse, regs, b_gone, pulse_after);
      model_write(32'h4, 32'hDEADBEEF, 4'hF);
      checks++;
      if (b_ok !== 1'b1) begin errors++; $display("FAIL wr1_bvalid: got %b want 1", b_ok); end
      checks++;
      if (resp !== 2'b00) begin errors++; $display("FAIL wr1_bresp: got %b want 00", resp); end
      checks++;
      if (regs[32 +: 32] !== 32'hDEADBEEF) begin
         errors++; $display("FAIL wr1_slot1: got %h want deadbeef", regs[32 +: 32]);
      end
      checks++;
      if (pulse !== 16'h0002) begin errors++; $display("FAIL wr1_pulse: got %h want 0002", pulse); end
      checks++;
      if ({b_gone, pulse_after} !== {1'b1, 16'h0}) begin
         errors++; $display("FAIL wr1_after: got %b/%h want 1/0000", b_gone, pulse_after);
      end
      axi_read(32'h4, r_ok, data, resp, r_gone);
      checks++;
      if ({r_ok, r_gone, resp, data} !== {1'b1, 1'b1, 2'b00, 32'hDEADBEEF}) begin
         errors++;
         $display("FAIL rd1: got ok=%b gone=%b resp=%b data=%h want 1 1 00 deadbeef",
                  r_ok, r_gone, resp, data);
      end
   endtask

   task automatic test_w_before_aw();
      logic [31:0] d;
      d = $urandom;
      @(negedge clk);
      awaddr = 32'h8; wdata = d; wstrb = 4'hF; wvalid = 1;
      @(posedge clk);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         wvalid = 0;
         checks++;
         if ({wready, awready, bvalid} !== 3'b010) begin
            errors++;
            $display("FAIL wfirst_ready_c%0d: got wr/aw/b=%b want 010", c, {wready, awready, bvalid});
         end
         if (c == 2) awvalid = 1;
         @(posedge clk);
      end
      @(negedge clk);
      awvalid = 0;
      model_write(32'h8, d, 4'hF);
      checks++;
      if ({bvalid, bresp} !== 3'b100) begin
         errors++; $display("FAIL wfirst_b: got bvalid/bresp=%b want 100", {bvalid, bresp});
      end
      checks++;
      if (regs_o !== model_flat()) begin
         errors++; $display("FAIL wfirst_regs: slot2 got %h want %h", regs_o[64 +: 32], d);
      end
      bready = 1;
      @(posedge clk);
      @(negedge clk);
      bready = 0;
   endtask

   task automatic test_ro();
      bit b_ok, b_gone, r_ok, r_gone;
      logic [1:0] resp;
      logic [15:0] pulse, pulse_after;
      logic [511:0] regs;
      logic [31:0] data;
      axi_write(32'h3C, $urandom, 4'hF, 0, 0, b_ok, resp, pulse, regs, b_gone, pulse_after);
      checks++;
      if ({b_ok, resp} !== 3'b110) begin
         errors++; $display("FAIL ro_wr_resp: got ok/resp=%b want 110", {b_ok, resp});
      end
      checks++;
      if ({regs, pulse} !== {model_flat(), 16'h0}) begin
         errors++; $display("FAIL ro_wr_nochange: pulse=%h slot15=%h", pulse, regs[480 +: 32]);
      end
      axi_read(32'h3C, r_ok, data, resp, r_gone);
      checks++;
      if ({r_ok, resp, data} !== {1'b1, 2'b00, 32'h12345678}) begin
         errors++; $display("FAIL ro_rd: got resp=%b data=%h want 00 12345678", resp, data);
      end
   endtask

   task automatic test_decerr();
      bit b_ok, b_gone, r_ok, r_gone;
      logic [1:0] resp;
      logic [15:0] pulse, pulse_after;
      logic [511:0] regs;
      logic [31:0] data;
      axi_read(32'h40, r_ok, data, resp, r_gone);
      checks++;
      if ({r_ok, resp, data} !== {1'b1, 2'b11, 32'h0}) begin
         errors++; $display("FAIL dec_rd40: got resp=%b data=%h want 11 0", resp, data);
      end
      axi_read(32'h8000_0004, r_ok, data, resp, r_gone);
      checks++;
      if ({r_ok, resp, data} !== {1'b1, 2'b11, 32'h0}) begin
         errors++; $display("FAIL dec_rdhigh: got resp=%b data=%h want 11 0", resp, data);
      end
      axi_write(32'h40, $urandom, 4'hF, 0, 0, b_ok, resp, pulse, regs, b_gone, pulse_after);
      checks++;
      if ({b_ok, resp} !== 3'b111) begin
         errors++; $display("FAIL dec_wr_resp: got ok/resp=%b want 111", {b_ok, resp});
      end
      checks++;
      if ({regs, pulse} !== {model_flat(), 16'h0}) begin
         errors++; $display("FAIL dec_wr_nochange: pulse=%h", pulse);
      end
   endtask

   task automatic test_strobe();
      bit b_ok, b_gone;
      logic [1:0] resp;
      logic [15:0] pulse, pulse_after;
      logic [511:0] regs;
      logic [31:0] want;
      axi_write(32'hC, 32'h0, 4'hF, 0, 0, b_ok, resp, pulse, regs, b_gone, pulse_after);
      model_write(32'hC, 32'h0, 4'hF);
      axi_write(32'hC, 32'hAABBCCDD, 4'b0101, 0, 0, b_ok, resp, pulse, regs, b_gone, pulse_after);
      model_write(32'hC, 32'hAABBCCDD, 4'b0101);
`ifdef VGA_AXIL_REGFILE_STRB_EN
      want = 32'h00BB00DD;
`else
      want = 32'hAABBCCDD;
`endif
      checks++;
      if ({resp, regs[96 +: 32]} !== {2'b00, want}) begin
         errors++; $display("FAIL strb_0101: got resp=%b val=%h want 00 %h", resp, regs[96 +: 32], want);
      end
      axi_write(32'hC, 32'h55555555, 4'h0, 0, 0, b_ok, resp, pulse, regs, b_gone, pulse_after);
      model_write(32'hC, 32'h55555555, 4'h0);
      checks++;
      if ({resp, pulse, regs} !== {2'b00, 16'h0008, model_flat()}) begin
         errors++;
         $display("FAIL strb_zero: got resp=%b pulse=%h val=%h want 00 0008 %h",
                  resp, pulse, regs[96 +: 32], model[3]);
      end
   endtask

   task automatic test_same_edge();
      bit b_ok, b_gone;
      logic [1:0] resp;
      logic [15:0] pulse, pulse_after;
      logic [511:0] regs;
      logic [31:0] old_v, new_v;
      old_v = $urandom;
      new_v = ~old_v;
      axi_write(32'h1C, old_v, 4'hF, 0, 0, b_ok, resp, pulse, regs, b_gone, pulse_after);
      model_write(32'h1C, old_v, 4'hF);
      @(negedge clk);
      araddr = 32'h1C; arvalid = 1;
      awaddr = 32'h1C; awvalid = 1; wdata = new_v; wstrb = 4'hF; wvalid = 1;
      @(posedge clk);
      @(negedge clk);
      arvalid = 0; awvalid = 0; wvalid = 0;
      model_write(32'h1C, new_v, 4'hF);
      checks++;
      if ({rvalid, rdata} !== {1'b1, old_v}) begin
         errors++; $display("FAIL same_edge_rd: got rvalid=%b rdata=%h want 1 %h", rvalid, rdata, old_v);
      end
      checks++;
      if ({bvalid, regs_o} !== {1'b1, model_flat()}) begin
         errors++; $display("FAIL same_edge_wr: got bvalid=%b slot7=%h want 1 %h",
                            bvalid, regs_o[224 +: 32], new_v);
      end
      rready = 1; bready = 1;
      @(posedge clk);
      @(negedge clk);
      rready = 0; bready = 0;
   endtask

   task automatic test_back_to_back();
      logic [31:0] d [4];
      int n, nb;
      for (int i = 0; i < 4; i++) d[i] = $urandom;
      n = 0; nb = 0;
      bready = 1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (bvalid) nb++;
         if (awready && n < 4) begin
            awaddr = 32'h14; wdata = d[n]; wstrb = 4'hF; awvalid = 1; wvalid = 1;
            model_write(32'h14, d[n], 4'hF);
            n++;
         end else begin
            awvalid = 0; wvalid = 0;
         end
         @(posedge clk);
      end
      @(negedge clk);
      awvalid = 0; wvalid = 0; bready = 0;
      checks++;
      if (nb != 4) begin errors++; $display("FAIL b2b_count: got %0d responses want 4", nb); end
      checks++;
      if (regs_o !== model_flat()) begin
         errors++; $display("FAIL b2b_regs: slot5 got %h want %h", regs_o[160 +: 32], d[3]);
      end
   endtask

   task automatic test_random();
      bit b_ok, b_gone, r_ok, r_gone;
      logic [1:0] resp, want_resp;
      logic [15:0] pulse, pulse_after, want_pulse;
      logic [511:0] regs;
      logic [31:0] a, d, data, want_d;
      logic [3:0] s;
      for (int it = 0; it < 60; it++) begin
         a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 'h47));
         if ($urandom_range(0, 2) != 2) begin
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            want_resp  = exp_resp(a, 1'b1);
            want_pulse = exp_pulse(a);
            axi_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3),
                      b_ok, resp, pulse, regs, b_gone, pulse_after);
            model_write(a, d, s);
            checks++;
            if ({b_ok, b_gone, resp, pulse, pulse_after} !==
                {1'b1, 1'b1, want_resp, want_pulse, 16'h0}) begin
               errors++;
               $display("FAIL rnd_wr%0d a=%h: got ok=%b gone=%b resp=%b pulse=%h/%h want resp=%b pulse=%h",
                        it, a, b_ok, b_gone, resp, pulse, pulse_after, want_resp, want_pulse);
            end
            checks++;
            if (regs !== model_flat()) begin
               errors++; $display("FAIL rnd_regs%0d a=%h d=%h s=%b: regs_o differs from model", it, a, d, s);
            end
         end else begin
            want_resp = exp_resp(a, 1'b0);
            want_d    = exp_read(a);
            axi_read(a, r_ok, data, resp, r_gone);
            checks++;
            if ({r_ok, r_gone, resp, data} !== {1'b1, 1'b1, want_resp, want_d}) begin
               errors++;
               $display("FAIL rnd_rd%0d a=%h: got ok=%b gone=%b resp=%b data=%h want %b %h",
                        it, a, r_ok, r_gone, resp, data, want_resp, want_d);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      bit b_ok, b_gone;
      logic [1:0] resp;
      logic [15:0] pulse, pulse_after;
      logic [511:0] regs;
      logic [31:0] d;
      d = $urandom | 32'h1;
      @(negedge clk);
      awaddr = 32'h18; wdata = d; wstrb = 4'hF; awvalid = 1; wvalid = 1;
      @(posedge clk);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         awvalid = 0; wvalid = 0;
         checks++;
         if ({bvalid, bresp, regs_o[192 +: 32]} !== {1'b1, 2'b00, d}) begin
            errors++; $display("FAIL hold_b_c%0d: got bvalid=%b bresp=%b slot6=%h", c, bvalid,
                               bresp, regs_o[192 +: 32]);
         end
         @(posedge clk);
      end
      @(negedge clk);
      arst_n = 0;
      #1;
      model_clear();
      checks++;
      if ({bvalid, wr_pulse_o, regs_o} !== {1'b0, 16'h0, 512'h0}) begin
         errors++; $display("FAIL mid_rst: got bvalid=%b slot6=%h want 0 0", bvalid, regs_o[192 +: 32]);
      end
      @(negedge clk);
      arst_n = 1;
      @(negedge clk);
      awaddr = 32'h20; awvalid = 1;
      @(posedge clk);
      @(negedge clk);
      awvalid = 0;
      checks++;
      if ({awready, wready} !== 2'b01) begin
         errors++; $display("FAIL partial_aw: got aw/w ready=%b want 01", {awready, wready});
      end
      arst_n = 0;
      #1;
      checks++;
      if ({awready, wready} !== 2'b11) begin
         errors++; $display("FAIL partial_rst: got aw/w ready=%b want 11", {awready, wready});
      end
      @(negedge clk);
      arst_n = 1;
      d = $urandom;
      axi_write(32'h24, d, 4'hF, 0, 2, b_ok, resp, pulse, regs, b_gone, pulse_after);
      model_write(32'h24, d, 4'hF);
      checks++;
      if ({b_ok, resp, pulse, regs} !== {1'b1, 2'b00, 16'h0200, model_flat()}) begin
         errors++; $display("FAIL post_rst_wr: got ok=%b resp=%b pulse=%h slot9=%h slot8=%h",
                            b_ok, resp, pulse, regs[288 +: 32], regs[256 +: 32]);
      end
   endtask

   initial begin
      arst_n = 0;
      araddr = '0; arvalid = 0; rready = 0;
      awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
      for (int i = 0; i < 16; i++) hw_regs_i[i*32 +: 32] = $urandom;
      hw_regs_i[15*32 +: 32] = 32'h12345678;
      model_clear();
      repeat (2) @(negedge clk);
      arst_n = 1;
      @(negedge clk);
      test_reset();
      test_basic_write();
      test_w_before_aw();
      test_ro();
      test_decerr();
      test_strobe();
      test_same_edge();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
